// File: rtl/shr_pkg.sv
// Shared constants, state encoding and word type for the right-shift sequencer.
package shr_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shr_state_t;

    typedef logic [WIDTH_DEF-1:0] shr_word_t;

endpackage : shr_pkg

// File: rtl/shr1_stage.sv
// Combinational single-bit right shift: f = {fill, x[W-1:1]}, cout = x[0].
module shr1_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic             fill,
    output logic [WIDTH-1:0] f,
    output logic             cout
);

    // One-position shift with caller-supplied fill bit.
    always_comb begin
        f    = {fill, x[WIDTH-1:1]};
        cout = x[0];
    end

endmodule : shr1_stage

// File: rtl/shift_right_sequencer_8bit.sv
// Multi-cycle right shifter: one bit per clock through shr1_stage,
// start/busy/done handshake. Optional SHR_ARITH_EN adds an arith input
// selecting sign-preserving fill.
module shift_right_sequencer_8bit
    import shr_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             cout
`ifdef SHR_ARITH_EN
    ,
    input  logic             arith
`endif
);

    shr_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             cout_q,  cout_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [WIDTH-1:0] stage_f;
    logic             stage_cout;
    logic             fill;

`ifdef SHR_ARITH_EN
    logic             arith_q, arith_d;

    // Sign fill only when the captured mode requests it.
    always_comb begin
        fill = arith_q & shreg_q[WIDTH-1];
    end
`else
    // Logical shift: always fill with zero.
    always_comb begin
        fill = 1'b0;
    end
`endif

    shr1_stage #(.WIDTH(WIDTH)) u_stage (
        .x    (shreg_q),
        .fill (fill),
        .f    (stage_f),
        .cout (stage_cout)
    );

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        cout_d  = cout_q;
`ifdef SHR_ARITH_EN
        arith_d = arith_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = din;
                    count_d = amount;
                    cout_d  = 1'b0;
`ifdef SHR_ARITH_EN
                    arith_d = arith;
`endif
                    state_d = (amount == CNT_W'(0)) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = stage_f;
                cout_d  = stage_cout;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SHR_ARITH_EN
    // Captured shift mode for the operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arith_q <= 1'b0;
        end else begin
            arith_q <= arith_d;
        end
    end
`endif

    assign dout = shreg_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : shift_right_sequencer_8bit
